// File: rtl/keypad_entry_sequencer_pkg.sv
// Shared types and constants for the keypad entry sequencer.
package keypad_entry_sequencer_pkg;
  localparam int DIGIT_W = 4;
  localparam int CNT_W   = 3;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;
endpackage

// File: rtl/keypad_entry_sequencer_if.sv
// Keypad/timer handshake bundle; master drives requests, slave is the sequencer.
interface keypad_entry_sequencer_if #(parameter int NDIGITS = 4);
  logic                 enablen;
  logic [3:0]           code_in;
  logic                 loadn_in;
  logic                 clear_req;
  logic                 start_req;
  logic                 timer_done;
  logic [4*NDIGITS-1:0] digits_out;
  logic [2:0]           digit_cnt;
  logic                 load_timer;
  logic                 running;
  logic                 key_err;

  modport master (
    output enablen, code_in, loadn_in, clear_req, start_req, timer_done,
    input  digits_out, digit_cnt, load_timer, running, key_err
  );
  modport slave (
    input  enablen, code_in, loadn_in, clear_req, start_req, timer_done,
    output digits_out, digit_cnt, load_timer, running, key_err
  );
endinterface

// File: rtl/keypad_entry_sequencer_strobe_sync.sv
// Two-flop synchroniser for the encoder strobe plus a registered falling-edge pulse.
module keypad_entry_sequencer_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic event_pulse
);
  logic s1, s2, s3;

  // Flops idle high so a strobe already low at reset release still makes one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      s3          <= 1'b1;
      event_pulse <= 1'b0;
    end else begin
      s1          <= strobe_n;
      s2          <= s1;
      s3          <= s2;
      event_pulse <= s3 & ~s2;
    end
  end
endmodule

// File: rtl/keypad_entry_sequencer.sv
// Turns keypad strobes into a BCD entry buffer and hands it to the countdown timer.
module keypad_entry_sequencer
  import keypad_entry_sequencer_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  keypad_entry_sequencer_if.slave bus
);
  localparam int BUF_W = DIGIT_W * NDIGITS;

  state_t state, state_nx;
  logic   key_evt, key_live, code_ok, full;
  logic   key_ok, key_bad, clr_buf, load_go;

  keypad_entry_sequencer_strobe_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .strobe_n    (bus.loadn_in),
    .event_pulse (key_evt)
  );

  assign key_live = key_evt & ~bus.enablen;
  assign code_ok  = (bus.code_in <= BCD_MAX);
  assign full     = (bus.digit_cnt == CNT_W'(NDIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Priority clear > start > key; start has no effect from IDLE since nothing is entered.
  always_comb begin
    state_nx = state;
    key_ok   = 1'b0;
    key_bad  = 1'b0;
    clr_buf  = 1'b0;
    load_go  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.clear_req && key_live) begin
          if (code_ok) begin
            key_ok   = 1'b1;
            state_nx = ENTRY;
          end else begin
            key_bad  = 1'b1;
          end
        end
      end
      ENTRY: begin
        if (bus.clear_req) begin
          clr_buf  = 1'b1;
          state_nx = IDLE;
        end else if (bus.start_req) begin
          state_nx = LOAD;
        end else if (key_live) begin
          if (code_ok && !full) key_ok  = 1'b1;
          else                  key_bad = 1'b1;
        end
      end
      LOAD: begin
        if (bus.clear_req) begin
          clr_buf  = 1'b1;
          state_nx = IDLE;
        end else begin
          load_go  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.clear_req || bus.timer_done) begin
          clr_buf  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.digits_out <= '0;
      bus.digit_cnt  <= '0;
    end else if (clr_buf) begin
      bus.digits_out <= '0;
      bus.digit_cnt  <= '0;
    end else if (key_ok) begin
      bus.digits_out <= {bus.digits_out[BUF_W-DIGIT_W-1:0], bus.code_in};
      bus.digit_cnt  <= bus.digit_cnt + 3'd1;
    end
  end

  // The load pulse lines up with the first RUN cycle; buffer is frozen by then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.load_timer <= 1'b0;
      bus.key_err    <= 1'b0;
      bus.running    <= 1'b0;
    end else begin
      bus.load_timer <= load_go;
      bus.key_err    <= key_bad;
      bus.running    <= (state_nx == RUN);
    end
  end
endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Directed + randomized bench with a transaction-level model of the entry buffer.
module tb_keypad_entry_sequencer;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_sequencer_if #(.NDIGITS(ND)) bus ();
  keypad_entry_sequencer #(.NDIGITS(ND)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int n_err = 0, n_load = 0;
  logic [15:0] last_load = '0;

  // Pulse counters observed at the edge; outputs are registered so pre-edge values are stable.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.key_err) n_err <= n_err + 1;
      if (bus.load_timer) begin
        n_load    <= n_load + 1;
        last_load <= bus.digits_out;
      end
    end
  end

  // Reference model: entered digits in order, plus whether the timer owns the buffer.
  int q[$];
  bit run_m = 0;
  int e_err = 0, e_load = 0;

  function automatic int model_val();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".digits"}, int'(bus.digits_out), model_val());
    chk({tag, ".cnt"},    int'(bus.digit_cnt),  q.size());
    chk({tag, ".run"},    int'(bus.running),    int'(run_m));
    chk({tag, ".nerr"},   n_err,  e_err);
    chk({tag, ".nload"},  n_load, e_load);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int c, input bit en, input int hold);
    bus.enablen  = en;
    bus.code_in  = 4'(c);
    bus.loadn_in = 1'b0;
    step(hold);
    bus.loadn_in = 1'b1;
    step(6);
    bus.enablen  = 1'b0;
    if (!en && !run_m) begin
      if (c > 9 || q.size() == ND) e_err++;
      else                         q.push_back(c);
    end
  endtask

  task automatic start_op();
    bus.start_req = 1'b1; step(1); bus.start_req = 1'b0; step(4);
    if (!run_m && q.size() > 0) begin run_m = 1; e_load++; end
  endtask

  task automatic clear_op();
    bus.clear_req = 1'b1; step(1); bus.clear_req = 1'b0; step(3);
    q.delete(); run_m = 0;
  endtask

  task automatic done_op();
    bus.timer_done = 1'b1; step(1); bus.timer_done = 1'b0; step(3);
    if (run_m) begin q.delete(); run_m = 0; end
  endtask

  task automatic reset_pulse();
    bus.start_req = 1'b0; bus.clear_req = 1'b0;
    step(2); rst = 1'b0; step(4);
    q.delete(); run_m = 0;
  endtask

  initial begin
    bus.enablen = 1'b0; bus.code_in = '0; bus.loadn_in = 1'b1;
    bus.clear_req = 1'b0; bus.start_req = 1'b0; bus.timer_done = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst.digits", int'(bus.digits_out), 0);
    chk("rst.cnt",    int'(bus.digit_cnt),  0);
    chk("rst.pulses", int'({bus.load_timer, bus.key_err, bus.running}), 0);
    step(2); rst = 1'b0; step(2);

    // Strobe latency: low at edge k, digit visible only after edge k+3.
    bus.code_in = 4'd1; bus.loadn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lat.k2", int'(bus.digit_cnt), 0);
    @(posedge clk);
    #1 chk("lat.k3", int'(bus.digits_out), 16'h0001);
    step(6); bus.loadn_in = 1'b1; step(6);
    q.push_back(1);

    // 1,2,3,4 entry (the 1 above is the first digit)
    for (int i = 2; i <= 4; i++) press(i, 1'b0, 10);
    chk_all("seq1234");
    chk("seq1234.val", int'(bus.digits_out), 16'h1234);

    // Full buffer and non-BCD code both rejected
    press(5, 1'b0, 10);
    chk_all("full");
    clear_op();
    press(8, 1'b0, 3);
    press(10, 1'b0, 3);
    chk_all("code_a");

    // Load/run/done with 0,9
    clear_op();
    press(0, 1'b0, 4); press(9, 1'b0, 4);
    start_op();
    chk("load.val", int'(last_load), 16'h0009);
    press(7, 1'b0, 4);
    chk_all("run.key");
    done_op();
    chk_all("done");

    // Start held through the end of RUN does not restart
    press(6, 1'b0, 2);
    bus.start_req = 1'b1; step(4);
    run_m = 1; e_load++;
    bus.timer_done = 1'b1; step(1); bus.timer_done = 1'b0; step(6);
    bus.start_req = 1'b0;
    q.delete(); run_m = 0;
    chk_all("start_held");

    // Start and clear together: clear wins
    press(3, 1'b0, 2);
    bus.start_req = 1'b1; bus.clear_req = 1'b1; step(1);
    bus.start_req = 1'b0; bus.clear_req = 1'b0; step(4);
    q.delete();
    chk_all("start_clr");

    // Long hold gives one shift; disabled press does nothing
    press(3, 1'b0, 50);
    chk_all("hold50");
    press(5, 1'b1, 5);
    chk_all("disabled");

    // Reset while in LOAD
    bus.start_req = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_load.out", int'({bus.digits_out, bus.digit_cnt, bus.load_timer, bus.running}), 0);
    reset_pulse();
    chk_all("rst_load");

    // Reset while in RUN
    press(4, 1'b0, 2);
    start_op();
    chk_all("pre_rst_run");
    #2 rst = 1'b1;
    #1 chk("rst_run.out", int'({bus.digits_out, bus.digit_cnt, bus.running}), 0);
    reset_pulse();
    chk_all("rst_run");

    // Randomized operation mix against the model
    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 6)       press(int'($urandom_range(0, 11)), ($urandom_range(0, 9) == 0), int'($urandom_range(1, 12)));
      else if (op == 6) start_op();
      else if (op == 7) clear_op();
      else              done_op();
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
